// File: rtl/control_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : control_unit_if
// Description : Bundle between the control unit and the RISC datapath.
//               Datapath side supplies the current instruction, the ALU's
//               raw flags and the program-load request; the control unit
//               drives every datapath strobe plus status (flags, halted,
//               retired-instruction count).
//               modport master : control unit side
//               modport slave  : datapath / loader side
// Revision    : 1.0 - initial release
// ============================================================================
interface control_unit_if #(
    parameter int CNT_W = 16
);
    // Loader / datapath -> control unit
    logic              prog_mode;
    logic [15:0]       mem_instr_out;
    logic              Pre_C;
    logic              Pre_V;
    logic              Pre_Z;
    logic              Pre_N;

    // Control unit -> datapath
    logic              test_normal;
    logic              dp_clr;
    logic              flag_HLT;
    logic              RF_write_en;
    logic              data_write_en;
    logic              flag_mem_RF;
    logic              flag_ALU_RF;
    logic              flag_Rm_RF;
    logic              flag_PC_RF;
    logic              LHI;
    logic              LLI;
    logic              Src_ALU_B;
    logic              Src_Read_B;
    logic              ADC;
    logic              SUB;
    logic              SBB;
    logic              JMP;
    logic              BRANCH;
    logic              flag_label_PC;
    logic              flag_Rm_PC;
    logic              flag_Rd_PC;
    logic              flag_OutR;
    logic [3:0]        flags;
    logic              halted;
    logic [CNT_W-1:0]  instr_count;

    modport master (
        input  prog_mode, mem_instr_out, Pre_C, Pre_V, Pre_Z, Pre_N,
        output test_normal, dp_clr, flag_HLT, RF_write_en, data_write_en,
               flag_mem_RF, flag_ALU_RF, flag_Rm_RF, flag_PC_RF, LHI, LLI,
               Src_ALU_B, Src_Read_B, ADC, SUB, SBB, JMP, BRANCH,
               flag_label_PC, flag_Rm_PC, flag_Rd_PC, flag_OutR,
               flags, halted, instr_count
    );

    modport slave (
        output prog_mode, mem_instr_out, Pre_C, Pre_V, Pre_Z, Pre_N,
        input  test_normal, dp_clr, flag_HLT, RF_write_en, data_write_en,
               flag_mem_RF, flag_ALU_RF, flag_Rm_RF, flag_PC_RF, LHI, LLI,
               Src_ALU_B, Src_Read_B, ADC, SUB, SBB, JMP, BRANCH,
               flag_label_PC, flag_Rm_PC, flag_Rd_PC, flag_OutR,
               flags, halted, instr_count
    );
endinterface
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module      : control_unit
// Description : Single-cycle instruction decoder and run-control FSM for the
//               RISC datapath. Sequences LOAD -> CLEAR -> RUN -> HALT,
//               decodes mem_instr_out into datapath strobes with zero
//               latency, keeps the architectural {C,V,Z,N} register used by
//               conditional branches, and counts retired instructions.
// Ports       : clk  - system clock, rising edge
//               clr  - synchronous active-high reset
//               bus  - control_unit_if.master (instruction, ALU flags,
//                      prog_mode in; strobes, flags, halted, count out)
// Revision    : 1.0 - initial release
// ============================================================================
module control_unit #(
    parameter int CNT_W = 16
) (
    input  wire logic            clk,
    input  wire logic            clr,
    control_unit_if.master       bus
);

    // ------------------------------------------------------------------
    // Opcodes (instruction bits [15:11])
    // ------------------------------------------------------------------
    localparam logic [4:0] c_OP_ALU  = 5'b00000;
    localparam logic [4:0] c_OP_LLI  = 5'b00001;
    localparam logic [4:0] c_OP_LHI  = 5'b00010;
    localparam logic [4:0] c_OP_LDR  = 5'b00011;
    localparam logic [4:0] c_OP_STR  = 5'b00101;
    localparam logic [4:0] c_OP_ADDI = 5'b00111;
    localparam logic [4:0] c_OP_SUBI = 5'b01000;
    localparam logic [4:0] c_OP_MOV  = 5'b01001;
    localparam logic [4:0] c_OP_JMP  = 5'b10000;
    localparam logic [4:0] c_OP_JAL  = 5'b10001;
    localparam logic [4:0] c_OP_JR   = 5'b10010;
    localparam logic [4:0] c_OP_JALR = 5'b10011;
    localparam logic [4:0] c_OP_OUT  = 5'b11100;
    localparam logic [4:0] c_OP_HLT  = 5'b11111;
    // Branches occupy two opcodes (11000, 11001): match on bits [15:12]
    localparam logic [3:0] c_BR_PFX  = 4'b1100;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    typedef struct packed {
        logic rf_we;
        logic data_we;
        logic mem_rf;
        logic alu_rf;
        logic rm_rf;
        logic pc_rf;
        logic lhi;
        logic lli;
        logic src_alu_b;
        logic src_read_b;
        logic adc;
        logic sub;
        logic sbb;
        logic jmp;
        logic branch;
        logic label_pc;
        logic rm_pc;
        logic rd_pc;
        logic out_r;
    } strobes_t;

    state_t            state_q, state_d;
    logic [3:0]        flags_q, flags_d;   // {C,V,Z,N}
    logic [CNT_W-1:0]  count_q, count_d;

    logic [4:0]        w_opcode;
    logic [3:0]        w_cond;
    logic [1:0]        w_funct;
    logic              w_cond_true;
    logic              w_is_alu_op;        // op that commits ALU flags
    logic              w_is_hlt;
    strobes_t          w_dec;              // raw decode, state-independent
    strobes_t          w_str;              // decode gated by RUN state
    logic              w_run;
    logic              w_test_normal;
    logic              w_dp_clr;
    logic              w_flag_hlt;
    logic              w_unused_bits;

    assign w_opcode = bus.mem_instr_out[15:11];
    assign w_cond   = bus.mem_instr_out[11:8];
    assign w_funct  = bus.mem_instr_out[1:0];

    // Operand fields are consumed by the datapath, not here
    assign w_unused_bits = ^bus.mem_instr_out[7:2];

    // ------------------------------------------------------------------
    // Branch condition against the registered flags, so an ALU op's
    // result is seen by a branch in the very next instruction.
    // ------------------------------------------------------------------
    always_comb begin
        w_cond_true = 1'b0;
        case (w_cond)
            4'b0000: w_cond_true =  flags_q[1];                          // EQ
            4'b0001: w_cond_true = ~flags_q[1];                          // NE
            4'b0010: w_cond_true =  flags_q[3];                          // CS
            4'b0011: w_cond_true = ~flags_q[3];                          // CC
            4'b0100: w_cond_true =  flags_q[0];                          // MI
            4'b0101: w_cond_true = ~flags_q[0];                          // PL
            4'b0110: w_cond_true =  flags_q[2];                          // VS
            4'b0111: w_cond_true = ~flags_q[2];                          // VC
            4'b1000: w_cond_true =  flags_q[3] & ~flags_q[1];            // HI
            4'b1001: w_cond_true = ~flags_q[3] |  flags_q[1];            // LS
            4'b1010: w_cond_true = (flags_q[0] == flags_q[2]);           // GE
            4'b1011: w_cond_true = (flags_q[0] != flags_q[2]);           // LT
            4'b1100: w_cond_true = ~flags_q[1] & (flags_q[0] == flags_q[2]); // GT
            4'b1101: w_cond_true =  flags_q[1] | (flags_q[0] != flags_q[2]); // LE
            4'b1110: w_cond_true = 1'b1;                                 // AL
            default: w_cond_true = 1'b0;                                 // never
        endcase
    end

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    always_comb begin
        w_dec       = '0;
        w_is_alu_op = 1'b0;
        w_is_hlt    = 1'b0;
        case (w_opcode)
            c_OP_ALU: begin
                w_dec.alu_rf = 1'b1;
                w_dec.rf_we  = 1'b1;
                w_is_alu_op  = 1'b1;
                case (w_funct)
                    2'b01:   w_dec.adc = 1'b1;
                    2'b10:   w_dec.sub = 1'b1;
                    2'b11:   w_dec.sbb = 1'b1;
                    default: ;                      // plain ADD
                endcase
            end
            c_OP_LLI: begin
                w_dec.lli   = 1'b1;
                w_dec.rf_we = 1'b1;
            end
            c_OP_LHI: begin
                w_dec.lhi        = 1'b1;
                w_dec.src_read_b = 1'b1;
                w_dec.rf_we      = 1'b1;
            end
            c_OP_LDR: begin
                w_dec.mem_rf    = 1'b1;
                w_dec.src_alu_b = 1'b1;
                w_dec.rf_we     = 1'b1;
            end
            c_OP_STR: begin
                w_dec.data_we    = 1'b1;
                w_dec.src_alu_b  = 1'b1;
                w_dec.src_read_b = 1'b1;
            end
            c_OP_ADDI: begin
                w_dec.alu_rf    = 1'b1;
                w_dec.src_alu_b = 1'b1;
                w_dec.rf_we     = 1'b1;
                w_is_alu_op     = 1'b1;
            end
            c_OP_SUBI: begin
                w_dec.alu_rf    = 1'b1;
                w_dec.src_alu_b = 1'b1;
                w_dec.rf_we     = 1'b1;
                w_dec.sub       = 1'b1;
                w_is_alu_op     = 1'b1;
            end
            c_OP_MOV: begin
                w_dec.rm_rf = 1'b1;
                w_dec.rf_we = 1'b1;
            end
            c_OP_JMP: begin
                w_dec.jmp      = 1'b1;
                w_dec.label_pc = 1'b1;
            end
            c_OP_JAL: begin
                w_dec.jmp      = 1'b1;
                w_dec.label_pc = 1'b1;
                w_dec.pc_rf    = 1'b1;
                w_dec.rf_we    = 1'b1;
            end
            c_OP_JR: begin
                w_dec.rd_pc = 1'b1;
            end
            c_OP_JALR: begin
                w_dec.rm_pc = 1'b1;
                w_dec.pc_rf = 1'b1;
                w_dec.rf_we = 1'b1;
            end
            c_OP_OUT: begin
                w_dec.out_r = 1'b1;
            end
            c_OP_HLT: begin
                w_is_hlt = 1'b1;
            end
            default: begin
                // Branch pair; everything else decodes as NOP
                if (w_opcode[4:1] == c_BR_PFX) begin
                    w_dec.branch = w_cond_true;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Run-control FSM: next state, flag/count updates, mode outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        flags_d       = flags_q;
        count_d       = count_q;
        w_run         = 1'b0;
        w_test_normal = 1'b0;
        w_dp_clr      = 1'b0;
        w_flag_hlt    = 1'b0;
        case (state_q)
            S_LOAD: begin
                w_test_normal = 1'b1;
                if (!bus.prog_mode) begin
                    // Clearing on LOAD exit means CLEAR already shows zeros
                    state_d = S_CLEAR;
                    flags_d = '0;
                    count_d = '0;
                end
            end
            S_CLEAR: begin
                w_dp_clr = 1'b1;
                flags_d  = '0;
                count_d  = '0;
                state_d  = S_RUN;
            end
            S_RUN: begin
                w_run = 1'b1;
                if (w_is_hlt) begin
                    // PC freezes on the HLT itself and it is not retired
                    state_d = S_HALT;
                end else begin
                    w_flag_hlt = 1'b1;
                    count_d    = count_q + CNT_W'(1);
                end
                if (w_is_alu_op) begin
                    flags_d = {bus.Pre_C, bus.Pre_V, bus.Pre_Z, bus.Pre_N};
                end
                // A load request outranks HLT
                if (bus.prog_mode) begin
                    state_d = S_LOAD;
                end
            end
            S_HALT: begin
                if (bus.prog_mode) begin
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_LOAD;
            flags_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            count_q <= count_d;
        end
    end

    // Strobes only leave the block while executing
    assign w_str = w_run ? w_dec : '0;

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.test_normal   = w_test_normal;
    assign bus.dp_clr        = w_dp_clr;
    assign bus.flag_HLT      = w_flag_hlt;
    assign bus.RF_write_en   = w_str.rf_we;
    assign bus.data_write_en = w_str.data_we;
    assign bus.flag_mem_RF   = w_str.mem_rf;
    assign bus.flag_ALU_RF   = w_str.alu_rf;
    assign bus.flag_Rm_RF    = w_str.rm_rf;
    assign bus.flag_PC_RF    = w_str.pc_rf;
    assign bus.LHI           = w_str.lhi;
    assign bus.LLI           = w_str.lli;
    assign bus.Src_ALU_B     = w_str.src_alu_b;
    assign bus.Src_Read_B    = w_str.src_read_b;
    assign bus.ADC           = w_str.adc;
    assign bus.SUB           = w_str.sub;
    assign bus.SBB           = w_str.sbb;
    assign bus.JMP           = w_str.jmp;
    assign bus.BRANCH        = w_str.branch;
    assign bus.flag_label_PC = w_str.label_pc;
    assign bus.flag_Rm_PC    = w_str.rm_pc;
    assign bus.flag_Rd_PC    = w_str.rd_pc;
    assign bus.flag_OutR     = w_str.out_r;
    assign bus.flags         = flags_q;
    assign bus.halted        = (state_q == S_HALT);
    assign bus.instr_count   = count_q;

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_unit
// Description : Self-checking bench for control_unit. Directed decode table,
//               hand-written sequences for load/clear/run/halt/reset corner
//               cases, then random instruction streams checked against a
//               table-and-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_unit;

    localparam int CW = 4;   // narrow counter so wrap-around is reached quickly

    logic clk = 1'b0;
    logic clr;

    control_unit_if #(.CNT_W(CW)) bus ();

    control_unit #(.CNT_W(CW)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Strobe vector bit masks (MSB first order of dut_str)
    localparam logic [18:0] M_RFWE = 19'd1 << 18;
    localparam logic [18:0] M_DWE  = 19'd1 << 17;
    localparam logic [18:0] M_MEM  = 19'd1 << 16;
    localparam logic [18:0] M_ALU  = 19'd1 << 15;
    localparam logic [18:0] M_RM   = 19'd1 << 14;
    localparam logic [18:0] M_PCRF = 19'd1 << 13;
    localparam logic [18:0] M_LHI  = 19'd1 << 12;
    localparam logic [18:0] M_LLI  = 19'd1 << 11;
    localparam logic [18:0] M_SALU = 19'd1 << 10;
    localparam logic [18:0] M_SRB  = 19'd1 << 9;
    localparam logic [18:0] M_ADC  = 19'd1 << 8;
    localparam logic [18:0] M_SUB  = 19'd1 << 7;
    localparam logic [18:0] M_SBB  = 19'd1 << 6;
    localparam logic [18:0] M_JMP  = 19'd1 << 5;
    localparam logic [18:0] M_BR   = 19'd1 << 4;
    localparam logic [18:0] M_LBL  = 19'd1 << 3;
    localparam logic [18:0] M_RMPC = 19'd1 << 2;
    localparam logic [18:0] M_RDPC = 19'd1 << 1;
    localparam logic [18:0] M_OUT  = 19'd1 << 0;

    logic [18:0] dut_str;
    assign dut_str = {bus.RF_write_en, bus.data_write_en, bus.flag_mem_RF,
                      bus.flag_ALU_RF, bus.flag_Rm_RF, bus.flag_PC_RF,
                      bus.LHI, bus.LLI, bus.Src_ALU_B, bus.Src_Read_B,
                      bus.ADC, bus.SUB, bus.SBB, bus.JMP, bus.BRANCH,
                      bus.flag_label_PC, bus.flag_Rm_PC, bus.flag_Rd_PC,
                      bus.flag_OutR};

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] ins;
        logic [18:0] want;
    } vec_t;

    vec_t        tbl [$];
    logic [18:0] op_mask [logic [4:0]];
    logic [18:0] alu_mode [4];

    // ------------------------------------------------------------------
    // Reference model: opcode lookup table plus condition pairs, where
    // odd condition codes are the negation of the even one below them.
    // ------------------------------------------------------------------
    function automatic bit br_taken(logic [3:0] cond, logic [3:0] f);
        bit c = f[3];
        bit v = f[2];
        bit z = f[1];
        bit n = f[0];
        bit t;
        case (cond[3:1])
            3'd0:    t = z;
            3'd1:    t = c;
            3'd2:    t = n;
            3'd3:    t = v;
            3'd4:    t = c && !z;
            3'd5:    t = (n == v);
            3'd6:    t = !z && (n == v);
            default: t = 1'b1;
        endcase
        return t ^ cond[0];
    endfunction

    function automatic logic [18:0] model_str(logic [15:0] ins, logic [3:0] f);
        logic [4:0] op = ins[15:11];
        if (op == 5'b00000) return M_ALU | M_RFWE | alu_mode[ins[1:0]];
        if (ins[15:12] == 4'b1100) return br_taken(ins[11:8], f) ? M_BR : 19'd0;
        if (op_mask.exists(op)) return op_mask[op];
        return 19'd0;
    endfunction

    function automatic bit model_alu(logic [4:0] op);
        return (op == 5'b00000) || (op == 5'b00111) || (op == 5'b01000);
    endfunction

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, want);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic [15:0] ins, logic [3:0] pre);
        bus.mem_instr_out = ins;
        {bus.Pre_C, bus.Pre_V, bus.Pre_Z, bus.Pre_N} = pre;
    endtask

    // One clock: drive after the edge, let it settle, return mid-cycle
    task automatic step(logic [15:0] ins, logic [3:0] pre);
        cyc();
        drive(ins, pre);
        #3;
    endtask

    // From a LOAD cycle with prog_mode=1: drop prog_mode, pass through
    // CLEAR, return in the middle of the CLEAR cycle.
    task automatic enter_run(bit detailed);
        cyc();
        bus.prog_mode = 1'b0;
        drive(16'h2845, 4'hF);
        #3;
        if (detailed) begin
            chk("load_test_normal", 32'(bus.test_normal), 32'd1);
            chk("load_strobes", 32'(dut_str), 32'd0);
            chk("load_flag_HLT", 32'(bus.flag_HLT), 32'd0);
        end
        cyc();
        #3;
        if (detailed) begin
            chk("clear_dp_clr", 32'(bus.dp_clr), 32'd1);
            chk("clear_test_normal", 32'(bus.test_normal), 32'd0);
            chk("clear_flag_HLT", 32'(bus.flag_HLT), 32'd0);
            chk("clear_strobes", 32'(dut_str), 32'd0);
            chk("clear_halted", 32'(bus.halted), 32'd0);
        end
    endtask

    // Request load from RUN/HALT and confirm LOAD is reached next cycle
    task automatic go_load();
        cyc();
        bus.prog_mode = 1'b1;
        drive(16'h2000, 4'h0);
        #3;
        cyc();
        #3;
        chk("to_load_test_normal", 32'(bus.test_normal), 32'd1);
        chk("to_load_halted", 32'(bus.halted), 32'd0);
        chk("to_load_strobes", 32'(dut_str), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  mf;
        int          mc;
        logic [15:0] ins;
        logic [3:0]  pre;
        logic [4:0]  alu_ops [3];
        int          n;
        int          sel;

        // Model tables
        op_mask[5'b00001] = M_LLI | M_RFWE;
        op_mask[5'b00010] = M_LHI | M_SRB | M_RFWE;
        op_mask[5'b00011] = M_MEM | M_SALU | M_RFWE;
        op_mask[5'b00101] = M_DWE | M_SALU | M_SRB;
        op_mask[5'b00111] = M_ALU | M_SALU | M_RFWE;
        op_mask[5'b01000] = M_ALU | M_SALU | M_RFWE | M_SUB;
        op_mask[5'b01001] = M_RM | M_RFWE;
        op_mask[5'b10000] = M_JMP | M_LBL;
        op_mask[5'b10001] = M_JMP | M_LBL | M_PCRF | M_RFWE;
        op_mask[5'b10010] = M_RDPC;
        op_mask[5'b10011] = M_RMPC | M_PCRF | M_RFWE;
        op_mask[5'b11100] = M_OUT;
        alu_mode[0] = 19'd0;
        alu_mode[1] = M_ADC;
        alu_mode[2] = M_SUB;
        alu_mode[3] = M_SBB;
        alu_ops[0] = 5'b00000;
        alu_ops[1] = 5'b00111;
        alu_ops[2] = 5'b01000;

        // Directed decode table, applied with all flags 0
        tbl.push_back('{16'b00011_001_000_00000, M_MEM | M_SALU | M_RFWE});
        tbl.push_back('{16'b00000_011_010_001_10, M_SUB | M_ALU | M_RFWE});
        tbl.push_back('{16'h0124, M_ALU | M_RFWE});
        tbl.push_back('{16'h0001, M_ALU | M_RFWE | M_ADC});
        tbl.push_back('{16'h0003, M_ALU | M_RFWE | M_SBB});
        tbl.push_back('{16'h08AB, M_LLI | M_RFWE});
        tbl.push_back('{16'h10CD, M_LHI | M_SRB | M_RFWE});
        tbl.push_back('{16'h2845, M_DWE | M_SALU | M_SRB});
        tbl.push_back('{16'h3801, M_ALU | M_SALU | M_RFWE});
        tbl.push_back('{16'h4002, M_ALU | M_SALU | M_RFWE | M_SUB});
        tbl.push_back('{16'h4810, M_RM | M_RFWE});
        tbl.push_back('{16'h8010, M_JMP | M_LBL});
        tbl.push_back('{16'h8810, M_JMP | M_LBL | M_PCRF | M_RFWE});
        tbl.push_back('{16'h9000, M_RDPC});
        tbl.push_back('{16'h9800, M_RMPC | M_PCRF | M_RFWE});
        tbl.push_back('{16'hE000, M_OUT});
        tbl.push_back('{16'h2000, 19'd0});          // NOP 00100
        tbl.push_back('{16'hF000, 19'd0});          // NOP 11110
        tbl.push_back('{16'hD000, 19'd0});          // NOP 11010
        tbl.push_back('{16'hC005, 19'd0});          // EQ, Z=0
        tbl.push_back('{16'hC105, M_BR});           // NE, Z=0
        tbl.push_back('{16'hCF00, 19'd0});          // never
        tbl.push_back('{16'hC900, M_BR});           // LS (opcode 11001)

        // ---------------- reset ----------------
        clr = 1'b1;
        bus.prog_mode = 1'b1;
        drive(16'h2845, 4'hF);
        cyc();
        cyc();
        #3;
        chk("rst_test_normal", 32'(bus.test_normal), 32'd1);
        chk("rst_flag_HLT", 32'(bus.flag_HLT), 32'd0);
        chk("rst_dp_clr", 32'(bus.dp_clr), 32'd0);
        chk("rst_flags", 32'(bus.flags), 32'd0);
        chk("rst_strobes", 32'(dut_str), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        chk("rst_count", 32'(bus.instr_count), 32'd0);
        clr = 1'b0;

        // ---------------- load/run handoff + decode table ----------------
        enter_run(1'b1);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].ins, 4'h0);
            chk($sformatf("dec%0d_strobes", i), 32'(dut_str), 32'(tbl[i].want));
            chk($sformatf("dec%0d_flag_HLT", i), 32'(bus.flag_HLT), 32'd1);
            chk($sformatf("dec%0d_mode", i), 32'({bus.test_normal, bus.dp_clr}), 32'd0);
            chk($sformatf("dec%0d_count", i), 32'(bus.instr_count), 32'(i % 16));
        end

        // ---------------- flags and branch ----------------
        step(16'h4002, 4'b0010);                    // SUBI, Z=1
        step(16'hC007, 4'b1111);                    // EQ
        chk("beq_taken_flags", 32'(bus.flags), 32'h2);
        chk("beq_taken_strobes", 32'(dut_str), 32'(M_BR));
        step(16'h4002, 4'b0000);                    // SUBI, Z=0
        step(16'hC007, 4'b0000);
        chk("beq_not_flags", 32'(bus.flags), 32'h0);
        chk("beq_not_strobes", 32'(dut_str), 32'd0);
        step(16'hCE5A, 4'b0000);
        chk("bal_strobes", 32'(dut_str), 32'(M_BR));
        step(16'h4002, 4'b0001);                    // N=1, V=0
        step(16'hCB00, 4'b1010);                    // LT
        chk("blt_strobes", 32'(dut_str), 32'(M_BR));
        step(16'hCA00, 4'b0000);                    // GE
        chk("bge_strobes", 32'(dut_str), 32'd0);
        step(16'h4810, 4'hF);                       // MOV must not touch flags
        step(16'hC400, 4'h0);                       // MI
        chk("hold_flags", 32'(bus.flags), 32'h1);
        chk("bmi_strobes", 32'(dut_str), 32'(M_BR));

        // ---------------- halt ----------------
        go_load();
        enter_run(1'b0);
        step(16'h4810, 4'h0);
        step(16'hE000, 4'h0);
        step(16'h2000, 4'h0);
        step(16'hF800, 4'h0);
        chk("hlt_cycle_flag_HLT", 32'(bus.flag_HLT), 32'd0);
        chk("hlt_cycle_strobes", 32'(dut_str), 32'd0);
        chk("hlt_cycle_count", 32'(bus.instr_count), 32'd3);
        step(16'h2845, 4'h0);
        chk("halted", 32'(bus.halted), 32'd1);
        chk("halted_flag_HLT", 32'(bus.flag_HLT), 32'd0);
        chk("halted_strobes", 32'(dut_str), 32'd0);
        chk("halted_count", 32'(bus.instr_count), 32'd3);
        step(16'h2845, 4'h0);
        chk("halted_still", 32'(bus.halted), 32'd1);
        go_load();

        // ---------------- prog_mode beats HLT ----------------
        enter_run(1'b0);
        cyc();
        bus.prog_mode = 1'b1;
        drive(16'hF800, 4'h0);
        #3;
        chk("hlt_vs_load_flag_HLT", 32'(bus.flag_HLT), 32'd0);
        step(16'h2000, 4'h0);
        chk("hlt_vs_load_test_normal", 32'(bus.test_normal), 32'd1);
        chk("hlt_vs_load_halted", 32'(bus.halted), 32'd0);

        // ---------------- mid-run reset ----------------
        enter_run(1'b0);
        step(16'h3801, 4'hF);                       // ADDI sets all flags
        step(16'h2845, 4'h0);                       // STR
        chk("str_data_write_en", 32'(bus.data_write_en), 32'd1);
        chk("str_flags", 32'(bus.flags), 32'hF);
        clr = 1'b1;
        bus.prog_mode = 1'b1;
        cyc();
        #3;
        chk("midrst_data_write_en", 32'(bus.data_write_en), 32'd0);
        chk("midrst_test_normal", 32'(bus.test_normal), 32'd1);
        chk("midrst_count", 32'(bus.instr_count), 32'd0);
        chk("midrst_flags", 32'(bus.flags), 32'd0);
        chk("midrst_strobes", 32'(dut_str), 32'd0);
        clr = 1'b0;

        // ---------------- random streams ----------------
        for (int r = 0; r < 6; r++) begin
            enter_run(1'b0);
            mf = 4'h0;
            mc = 0;
            n  = $urandom_range(20, 60);
            for (int k = 0; k < n; k++) begin
                ins = 16'($urandom);
                sel = $urandom_range(0, 3);
                if (sel == 0) ins[15:12] = 4'b1100;
                else if (sel == 1) ins[15:11] = alu_ops[$urandom_range(0, 2)];
                if (ins[15:11] == 5'b11111) ins[15:11] = 5'b11110;
                pre = 4'($urandom);
                step(ins, pre);
                chk($sformatf("rnd_strobes ins=%04h", ins), 32'(dut_str), 32'(model_str(ins, mf)));
                chk("rnd_flags", 32'(bus.flags), 32'(mf));
                chk("rnd_count", 32'(bus.instr_count), 32'(mc));
                chk("rnd_flag_HLT", 32'(bus.flag_HLT), 32'd1);
                if (model_alu(ins[15:11])) mf = pre;
                mc = (mc + 1) % 16;
            end
            step(16'hF800, 4'($urandom));
            chk("rnd_hlt_strobes", 32'(dut_str), 32'd0);
            chk("rnd_hlt_count", 32'(bus.instr_count), 32'(mc));
            step(16'($urandom), 4'($urandom));
            chk("rnd_halted", 32'(bus.halted), 32'd1);
            chk("rnd_halted_flags", 32'(bus.flags), 32'(mf));
            go_load();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
